// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run control in, timing strobes/counters out of the VGA timing generator
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
);
  logic               en;
  logic               pix_tick;
  logic [CNT_W-1:0]   hCount;
  logic [CNT_W-1:0]   vCount;
  logic               hsync;
  logic               vsync;
  logic               bright;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  modport master (input en, output pix_tick, hCount, vCount, hsync, vsync, bright, line_start, frame_start, frame_cnt);
  modport slave  (output en, input pix_tick, hCount, vCount, hsync, vsync, bright, line_start, frame_start, frame_cnt);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/counter generator with a clk_50-to-pixel divider
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 2,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8
) (
  input logic           clk_50,
  input logic           reset,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [FRAME_W-1:0] frame_q;
  logic               tick, h_wrap;
  logic               pix_q, line_q, fstart_q, bright_q, hs_q, vs_q;
  always_comb begin
    tick   = vif.en && (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = tick ? '0 : div_q + 1'b1;
    h_wrap = h_q == CNT_W'(H_TOTAL - 1);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = !h_wrap ? v_q : (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
  end
  // levels are computed from the next position so they line up with the counters they describe
  always_ff @(posedge clk_50) begin
    if (reset) begin
      div_q    <= '0;
      h_q      <= CNT_W'(H_TOTAL - 1);
      v_q      <= CNT_W'(V_TOTAL - 1);
      frame_q  <= '1;
      pix_q    <= 1'b0;
      line_q   <= 1'b0;
      fstart_q <= 1'b0;
      bright_q <= 1'b0;
      hs_q     <= !HSYNC_POL;
      vs_q     <= !VSYNC_POL;
    end else begin
      pix_q    <= tick;
      line_q   <= tick && (h_d == '0);
      fstart_q <= tick && (h_d == '0) && (v_d == '0);
      if (vif.en) div_q <= div_d;
      if (tick) begin
        h_q      <= h_d;
        v_q      <= v_d;
        frame_q  <= (h_d == '0 && v_d == '0) ? frame_q + 1'b1 : frame_q;
        bright_q <= (h_d < CNT_W'(H_ACTIVE)) && (v_d < CNT_W'(V_ACTIVE));
        hs_q     <= ((h_d >= CNT_W'(HS_BEG)) && (h_d < CNT_W'(HS_BEG + H_SYNC))) == HSYNC_POL;
        vs_q     <= ((v_d >= CNT_W'(VS_BEG)) && (v_d < CNT_W'(VS_BEG + V_SYNC))) == VSYNC_POL;
      end
    end
  end
  assign vif.pix_tick    = pix_q;
  assign vif.hCount      = h_q;
  assign vif.vCount      = v_q;
  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.bright      = bright_q;
  assign vif.line_start  = line_q;
  assign vif.frame_start = fstart_q;
  assign vif.frame_cnt   = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a default 640x480 instance and a tiny 8x6 instance
module tb_vga_timing_gen;
  logic clk_50 = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int checks = 0;
  int fails = 0;
  always #10 clk_50 = ~clk_50;
  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) a_if ();
  vga_timing_gen_if #(.CNT_W(4), .FRAME_W(2)) b_if ();
  vga_timing_gen u_a (.clk_50(clk_50), .reset(rst_a), .vif(a_if.master));
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .CNT_W(4), .FRAME_W(2)
  ) u_b (.clk_50(clk_50), .reset(rst_b), .vif(b_if.master));

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    a_if.en = 1'b1;
    b_if.en = 1'b1;
    repeat (3) step();
    checks++; if (a_if.hCount !== 10'd799) begin fails++; $display("FAIL reset_h: got %0d want 799", a_if.hCount); end
    checks++; if (a_if.vCount !== 10'd524) begin fails++; $display("FAIL reset_v: got %0d want 524", a_if.vCount); end
    checks++; if (a_if.frame_cnt !== 8'hff) begin fails++; $display("FAIL reset_fc: got %0d want 255", a_if.frame_cnt); end
    checks++; if ({a_if.bright, a_if.hsync, a_if.vsync} !== 3'b011) begin fails++; $display("FAIL reset_levels: got %b want 011", {a_if.bright, a_if.hsync, a_if.vsync}); end
    checks++; if ({a_if.pix_tick, a_if.line_start, a_if.frame_start} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b want 000", {a_if.pix_tick, a_if.line_start, a_if.frame_start}); end
  endtask

  task automatic test_first_tick();
    rst_a = 1'b0;
    step();
    checks++; if (a_if.pix_tick !== 1'b0) begin fails++; $display("FAIL first_tick_early: got %b want 0", a_if.pix_tick); end
    step();
    checks++; if ({a_if.pix_tick, a_if.line_start, a_if.frame_start} !== 3'b111) begin fails++; $display("FAIL first_tick_pulses: got %b want 111", {a_if.pix_tick, a_if.line_start, a_if.frame_start}); end
    checks++; if (a_if.hCount !== 10'd0 || a_if.vCount !== 10'd0) begin fails++; $display("FAIL first_tick_pos: got %0d,%0d want 0,0", a_if.hCount, a_if.vCount); end
    checks++; if (a_if.frame_cnt !== 8'd0) begin fails++; $display("FAIL first_tick_fc: got %0d want 0", a_if.frame_cnt); end
    checks++; if ({a_if.bright, a_if.hsync, a_if.vsync} !== 3'b111) begin fails++; $display("FAIL first_tick_levels: got %b want 111", {a_if.bright, a_if.hsync, a_if.vsync}); end
  endtask

  task automatic test_line();
    int cyc = 0, hs_n = 0, br_n = 0, hs_first = -1, hs_last = -1, bad = 0;
    do begin
      step();
      cyc++;
      if (a_if.pix_tick) begin
        if (!a_if.hsync) begin
          hs_n++;
          if (hs_first < 0) hs_first = int'(a_if.hCount);
          hs_last = int'(a_if.hCount);
        end
        if (a_if.bright) br_n++;
        if (a_if.bright !== (a_if.hCount < 640) || a_if.hsync !== !(a_if.hCount >= 656 && a_if.hCount < 752) || a_if.vsync !== 1'b1) bad++;
      end
    end while (!a_if.line_start && cyc < 2000);
    checks++; if (cyc != 1600) begin fails++; $display("FAIL line_period: got %0d want 1600", cyc); end
    checks++; if (hs_n != 96) begin fails++; $display("FAIL line_hsync_width: got %0d want 96", hs_n); end
    checks++; if (hs_first != 656 || hs_last != 751) begin fails++; $display("FAIL line_hsync_span: got %0d..%0d want 656..751", hs_first, hs_last); end
    checks++; if (br_n != 640) begin fails++; $display("FAIL line_bright_ticks: got %0d want 640", br_n); end
    checks++; if (bad != 0) begin fails++; $display("FAIL line_levels: got %0d bad ticks want 0", bad); end
    checks++; if (a_if.vCount !== 10'd1 || a_if.frame_start !== 1'b0) begin fails++; $display("FAIL line_next: got v=%0d fs=%b want v=1 fs=0", a_if.vCount, a_if.frame_start); end
  endtask

  task automatic test_freeze();
    int cyc = 0, bad = 0;
    do begin step(); cyc++; end while (!(a_if.pix_tick && a_if.hCount == 300) && cyc < 2000);
    checks++; if (a_if.hCount !== 10'd300) begin fails++; $display("FAIL freeze_reach: got %0d want 300", a_if.hCount); end
    a_if.en = 1'b0;
    repeat (100) begin
      step();
      if (a_if.pix_tick || a_if.line_start || a_if.frame_start || a_if.hCount !== 10'd300 || a_if.vCount !== 10'd1 || a_if.hsync !== 1'b1 || a_if.bright !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL freeze_hold: got %0d bad cycles want 0", bad); end
    a_if.en = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (!a_if.pix_tick && cyc < 10);
    checks++; if (cyc != 2) begin fails++; $display("FAIL resume_latency: got %0d want 2", cyc); end
    checks++; if (a_if.hCount !== 10'd301) begin fails++; $display("FAIL resume_h: got %0d want 301", a_if.hCount); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    do begin step(); cyc++; end while (!(a_if.pix_tick && a_if.hCount == 400) && cyc < 2000);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    checks++; if (a_if.hCount !== 10'd799 || a_if.vCount !== 10'd524) begin fails++; $display("FAIL midreset_pos: got %0d,%0d want 799,524", a_if.hCount, a_if.vCount); end
    checks++; if ({a_if.bright, a_if.hsync, a_if.vsync, a_if.pix_tick} !== 4'b0110) begin fails++; $display("FAIL midreset_levels: got %b want 0110", {a_if.bright, a_if.hsync, a_if.vsync, a_if.pix_tick}); end
    checks++; if (a_if.frame_cnt !== 8'hff) begin fails++; $display("FAIL midreset_fc: got %0d want 255", a_if.frame_cnt); end
    step();
    checks++; if (a_if.frame_start !== 1'b0) begin fails++; $display("FAIL midreset_fs_early: got %b want 0", a_if.frame_start); end
    step();
    checks++; if (a_if.frame_start !== 1'b1 || a_if.hCount !== 10'd0 || a_if.frame_cnt !== 8'd0) begin fails++; $display("FAIL midreset_fs: got fs=%b h=%0d fc=%0d want 1,0,0", a_if.frame_start, a_if.hCount, a_if.frame_cnt); end
  endtask

  task automatic test_small();
    int hm = 0, vm = 0, fcm = 0, fs_n = 0, hs_n = 0, vs_n = 0, bad = 0;
    checks++; if (b_if.hCount !== 4'd7 || b_if.vCount !== 4'd5 || b_if.frame_cnt !== 2'd3) begin fails++; $display("FAIL small_reset: got %0d,%0d fc=%0d want 7,5 fc=3", b_if.hCount, b_if.vCount, b_if.frame_cnt); end
    checks++; if ({b_if.bright, b_if.hsync, b_if.vsync} !== 3'b000) begin fails++; $display("FAIL small_reset_levels: got %b want 000", {b_if.bright, b_if.hsync, b_if.vsync}); end
    rst_b = 1'b0;
    step();
    checks++; if ({b_if.pix_tick, b_if.frame_start, b_if.bright} !== 3'b111 || b_if.hCount !== 4'd0 || b_if.frame_cnt !== 2'd0) begin fails++; $display("FAIL small_first: got p/fs/br=%b h=%0d fc=%0d want 111,0,0", {b_if.pix_tick, b_if.frame_start, b_if.bright}, b_if.hCount, b_if.frame_cnt); end
    for (int i = 1; i <= 192; i++) begin
      step();
      hm = (hm == 7) ? 0 : hm + 1;
      if (hm == 0) vm = (vm == 5) ? 0 : vm + 1;
      if (hm == 0 && vm == 0) fcm = (fcm + 1) % 4;
      if (b_if.pix_tick !== 1'b1 || b_if.hCount !== hm || b_if.vCount !== vm || b_if.frame_cnt !== fcm
          || b_if.hsync !== (hm == 5 || hm == 6) || b_if.vsync !== (vm == 4) || b_if.bright !== (hm < 4 && vm < 3)
          || b_if.line_start !== (hm == 0) || b_if.frame_start !== (hm == 0 && vm == 0)) bad++;
      if (b_if.frame_start) fs_n++;
      if (b_if.hsync) hs_n++;
      if (b_if.vsync) vs_n++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL small_model: got %0d bad cycles want 0", bad); end
    checks++; if (fs_n != 4) begin fails++; $display("FAIL small_frames: got %0d want 4", fs_n); end
    checks++; if (b_if.frame_start !== 1'b1 || b_if.frame_cnt !== 2'd0) begin fails++; $display("FAIL small_fc_wrap: got fs=%b fc=%0d want 1,0", b_if.frame_start, b_if.frame_cnt); end
    checks++; if (hs_n != 48) begin fails++; $display("FAIL small_hsync_ticks: got %0d want 48", hs_n); end
    checks++; if (vs_n != 32) begin fails++; $display("FAIL small_vsync_ticks: got %0d want 32", vs_n); end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_line();
    test_freeze();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480@60Hz VGA timing generator.
- Derives a pixel-rate tick from the 50 MHz system clock by a configurable divider.
- Generates hsync/vsync/bright plus hCount/vCount for any VESA-style mode, with configurable sync polarity.
- Adds run/freeze control, line/frame start strobes and a frame counter for the downstream pixel/glyph pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); must be >= 1
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); must be >= 1
- HSYNC_POL, 0, asserted level of hsync (0 = active low)
- VSYNC_POL, 0, asserted level of vsync
- CLK_DIV, 2, clk_50 cycles per pixel (>= 1)
- CNT_W, 10, width of hCount/vCount; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, width of frame_cnt

Ports:
- clk_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  run enable; low freezes all timing state
- pix_tick  out  1  one-cycle pixel-rate strobe
- hCount  out  CNT_W  current pixel column, 0..H_TOTAL-1
- vCount  out  CNT_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at HSYNC_POL when asserted
- vsync  out  1  vertical sync at VSYNC_POL when asserted
- bright  out  1  high in the visible region
- line_start  out  1  one-cycle pulse when hCount becomes 0
- frame_start  out  1  one-cycle pulse when (hCount,vCount) becomes (0,0)
- frame_cnt  out  FRAME_W  index of the current frame

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset state, applied on a clk_50 edge with reset=1:
  - divider = 0, pix_tick = 0
  - hCount = H_TOTAL-1, vCount = V_TOTAL-1 (last pixel of the frame)
  - bright = 0; hsync = !HSYNC_POL; vsync = !VSYNC_POL
  - line_start = 0, frame_start = 0
  - frame_cnt = all ones
- Divider: counts 0..CLK_DIV-1 while en=1, then wraps.
  - pix_tick = 1 in the cycle following the edge at which divider = CLK_DIV-1 and en = 1.
  - CLK_DIV=1: pix_tick = 1 every cycle after an edge with en=1.
- Counters update only on edges where a tick is generated (the same edge that sets pix_tick).
  - hCount: +1, wraps H_TOTAL-1 -> 0.
  - On hCount wrap, vCount +1, wraps V_TOTAL-1 -> 0.
  - On wrap to (0,0), frame_cnt +1 modulo 2^FRAME_W. The first frame after reset is therefore frame 0.
- hsync, vsync and bright are registered on the same edge as the counters and are always consistent with the presented hCount/vCount (zero relative latency):
  - bright = (hCount < H_ACTIVE) && (vCount < V_ACTIVE)
  - hsync asserted iff H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted iff V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC
- Reset state is consistent with these rules, because H_BP, V_BP >= 1 keep the reset position in the back porch.
- line_start / frame_start: high for exactly one clk_50 cycle, coincident with pix_tick, when the new hCount = 0 / new position = (0,0). frame_start implies line_start.
- en=0: divider, counters and all levels hold; pix_tick, line_start, frame_start = 0. On re-enable, counting resumes from the held divider value.
- Reset mid-frame: the next edge with reset=1 forces the reset state regardless of en. reset takes priority over everything.

Test Plan:
- Defaults; release reset, en=1 -> first pix_tick 2 cycles after release; hCount=0, vCount=0, frame_start=1, line_start=1, frame_cnt=0, bright=1.
- Defaults, one line -> hsync=0 exactly for hCount 656..751 (96 ticks); bright=1 for hCount 0..639 when vCount<480; line period 1600 clk_50 cycles.
- Defaults, full frame -> vsync=0 for vCount 490..491; 307200 bright ticks per frame; frame_start period 840000 clk_50 cycles; frame_cnt 0->1->2.
- H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HSYNC_POL=1, VSYNC_POL=1, CLK_DIV=1, FRAME_W=2 -> H_TOTAL=8, V_TOTAL=6; hsync=1 at hCount 5..6; vsync=1 at vCount 4; frame_cnt wraps 3->0 on the 5th frame_start.
- Defaults; en=0 for 100 cycles mid-line at hCount=300 -> counters and outputs frozen, no pulses; after en=1, hCount=301 on the next tick.
- Defaults; reset=1 for one cycle at hCount=400, vCount=200 -> reset state on the next edge (hCount=799, vCount=524, bright=0, syncs high); frame_start 2 cycles after release.
